cmp_seq: RTL
============

CMP_SEQ -- requirements
Module: cmp_seq

Interface
REQ-001 SHALL have parameter N_COLS, default 21: column count, equal to the shift-register lane count.
REQ-002 SHALL have parameter DEPTH, default 21: beats per frame, equal to the shift-register length.
REQ-003 SHALL have parameter OUT_W, default 26: compressor result width.
REQ-004 SHALL have parameter LAT, default 0: compressor pipeline latency in cycles, range 0..7.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: row beat valid.
REQ-008 SHALL have port in_ready, output, 1 bit: row beat accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port in_data, input, N_COLS bits: one bit per column for the current beat.
REQ-010 SHALL have port sh_bits, output, N_COLS bits: drives shift-register serial inputs src0_..src{N_COLS-1}_.
REQ-011 SHALL have port sh_en, output, 1 bit: shift enable of the enable-capable shift register.
REQ-012 SHALL have port cmp_sum, input, OUT_W bits: compressor outputs dst0..dst{OUT_W-1} packed LSB-first.
REQ-013 SHALL have port res_valid, output, 1 bit: result valid.
REQ-014 SHALL have port res_ready, input, 1 bit: result consumer ready.
REQ-015 SHALL have port res_data, output, OUT_W bits: captured result.

Function
REQ-016 SHALL implement four states: IDLE, FILL, WAIT, HOLD.
REQ-017 In IDLE and FILL, in_ready SHALL be 1; in WAIT and HOLD it SHALL be 0.
REQ-018 Each accepted beat SHALL drive sh_en=1 and sh_bits=in_data combinationally in the same cycle.
REQ-019 sh_en SHALL be 0 in every cycle with no beat accepted, including in_valid gaps mid-frame; the beat count SHALL hold during gaps.
REQ-020 The first accepted beat SHALL move IDLE to FILL and set the beat count to 1.
REQ-021 The DEPTH-th accepted beat SHALL move the state to WAIT with the wait count at 0.
REQ-022 WAIT SHALL last exactly LAT+1 cycles; on its last cycle cmp_sum SHALL be registered into res_data, res_valid SHALL go to 1, and the state SHALL become HOLD.
REQ-023 If the last beat is accepted at edge E, res_valid SHALL rise at edge E+LAT+2.
REQ-024 In HOLD, res_data SHALL be stable and res_valid=1 until a cycle with res_ready=1; that handshake SHALL clear res_valid and return the state to IDLE.
REQ-025 res_ready while res_valid=0 SHALL be ignored.
REQ-026 The shift register SHALL NOT be cleared between frames; DEPTH shifts fully overwrite it.
REQ-027 The beat counter SHALL be ceil(log2(DEPTH+1)) bits wide; the wait counter SHALL be 3 bits wide.

Reset
REQ-028 rst=1 SHALL force, asynchronously: state IDLE, both counts 0, res_valid 0, res_data 0, sh_en 0, in_ready 0 while asserted.
REQ-029 Reset mid-frame SHALL abandon the partial frame; the next frame after reset SHALL produce a correct result without any flush.

Configuration
REQ-030 With CMP_SEQ_PERF_EN defined, the block SHALL add outputs frame_cnt[15:0] and stall_cnt[15:0], both reset to 0.
REQ-031 frame_cnt SHALL increment on each result handshake; stall_cnt SHALL increment on each HOLD cycle with res_ready=0; both SHALL wrap at 0xFFFF to 0.
REQ-032 Without CMP_SEQ_PERF_EN, these ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-033 Package cmp_pkg SHALL hold the N_COLS, DEPTH and OUT_W defaults and the state enum cmp_seq_state_t.
REQ-034 The block SHALL be a single module with no sub-modules; the bench SHALL instantiate cmp_seq, the enable-capable shift register and the compressor together.

Verification
REQ-035 21 all-ones beats back-to-back, LAT=0 -> res_valid at E+2, res_data=0x29FFFEB.
REQ-036 Beat 1 = 0x000001, beats 2..21 = 0 -> sh_en high for exactly 21 cycles, res_data=0x0000001.
REQ-037 in_valid gaps of 3 cycles after beats 5 and 17 -> sh_en low during gaps, same result as the gapless frame, in_ready=0 during WAIT.
REQ-038 res_ready held low for 10 cycles in HOLD -> res_data stable, new beats refused; with PERF_EN, stall_cnt=10 and frame_cnt=1 after the handshake.
REQ-039 rst pulsed after beat 9 -> outputs at reset values immediately; the next full all-ones frame yields 0x29FFFEB.
REQ-040 LAT=3 build -> res_valid at E+5; cmp_sum sampled exactly at the last WAIT cycle.

Source files
------------

// File: rtl/cmp_pkg.sv
// Purpose: shared defaults and state encoding for the cmp_seq frame sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cmp_pkg;

    // Default geometry: 21 columns x 21 beats, 26-bit compressor result.
    localparam int N_COLS_DEF = 21;
    localparam int DEPTH_DEF  = 21;
    localparam int OUT_W_DEF  = 26;

    // The wait counter only has to cover LAT = 0..7.
    localparam int WAIT_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } cmp_seq_state_t;

endpackage

// File: rtl/cmp_seq.sv
// Purpose: streams DEPTH row beats into an external enable-capable shift register,
//          waits out the external compressor latency and captures its sum.
// Latency: last beat accepted in the cycle starting at edge E -> res_valid high after edge E+LAT+2.
// Backpressure: in_ready low from the last beat until the result handshake; the result is
//               held stable while res_ready is low.
//
// Ports:
//   clk, rst             - rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    - row beat handshake, in_data carries one bit per column
//   sh_bits, sh_en       - serial inputs and shift enable of the external shift register
//   cmp_sum              - external compressor result (LSB-first)
//   res_valid/res_ready  - result handshake, res_data holds the captured sum
//   frame_cnt, stall_cnt - only when CMP_SEQ_PERF_EN is defined: completed results and
//                          HOLD cycles stalled by the consumer, both 16-bit wrapping
module cmp_seq
    import cmp_pkg::*;
#(
    parameter int N_COLS = N_COLS_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int LAT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_COLS-1:0] in_data,
    output logic [N_COLS-1:0] sh_bits,
    output logic              sh_en,
    input  logic [OUT_W-1:0]  cmp_sum,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OUT_W-1:0]  res_data
`ifdef CMP_SEQ_PERF_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(DEPTH - 1);
    localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(LAT);

    cmp_seq_state_t         state_q, state_d;
    logic [CNT_W-1:0]       beat_q, beat_d;
    logic [WAIT_CNT_W-1:0]  wait_q, wait_d;
    logic                   res_vld_q, res_vld_d;
    logic [OUT_W-1:0]       res_dat_q, res_dat_d;
    logic                   accept;

    // in_ready is gated by rst so nothing is offered to the shift register while reset
    // is held, even though the state register is already forced to IDLE.
    assign in_ready  = !rst && ((state_q == IDLE) || (state_q == FILL));
    assign accept    = in_valid && in_ready;
    assign sh_en     = accept;
    assign sh_bits   = in_data;
    assign res_valid = res_vld_q;
    assign res_data  = res_dat_q;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        wait_d    = wait_q;
        res_vld_d = res_vld_q;
        res_dat_d = res_dat_q;

        case (state_q)
            // IDLE always sits with beat_q == 0, so it shares the FILL counting path:
            // the first beat lands on 1, and DEPTH == 1 goes straight to WAIT.
            IDLE, FILL: begin
                if (accept) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = WAIT;
                        beat_d  = '0;
                        wait_d  = '0;
                    end else begin
                        state_d = FILL;
                        beat_d  = beat_q + CNT_W'(1);
                    end
                end
            end

            // LAT+1 cycles: the compressor output reflects the final shift on the last one.
            WAIT: begin
                if (wait_q == LAST_WAIT) begin
                    state_d   = HOLD;
                    wait_d    = '0;
                    res_vld_d = 1'b1;
                    res_dat_d = cmp_sum;
                end else begin
                    wait_d = wait_q + WAIT_CNT_W'(1);
                end
            end

            HOLD: begin
                if (res_ready) begin
                    state_d   = IDLE;
                    res_vld_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            wait_q    <= '0;
            res_vld_q <= 1'b0;
            res_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            wait_q    <= wait_d;
            res_vld_q <= res_vld_d;
            res_dat_q <= res_dat_d;
        end
    end

`ifdef CMP_SEQ_PERF_EN
    logic [15:0] frame_q;
    logic [15:0] stall_q;

    // Both counters wrap naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
            stall_q <= '0;
        end else if (state_q == HOLD) begin
            if (res_ready) begin
                frame_q <= frame_q + 16'd1;
            end else begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign frame_cnt = frame_q;
    assign stall_cnt = stall_q;
`endif

endmodule
